// File: rtl/hqm_aqed_enq_ingress_buf.sv
// Parity-checked ingress FIFO feeding the AQED core enqueue port.
// Latency: a good beat pushed in cycle N is on qed_aqed_enq_v in cycle N+1 (no bypass).
// Backpressure: in_ready tracks the registered occupancy; a full buffer refuses pushes even when a pull happens that cycle.
//
// Ports:
//   hqm_gated_clk / hqm_gated_rst_n : clock (rising edge) and async active-low reset
//   in_v / in_data / in_par / in_ready : upstream QED beat with odd parity, valid/ready
//   qed_aqed_enq_v / qed_aqed_enq_data / qed_aqed_enq_rdy : head-of-FIFO to AQED core
//   err_par_v / err_par_cnt : one-cycle parity-error pulse and saturating error count
//   cfg_hwm_clr / status_depth / status_hwm : high-water-mark clear, occupancy, high-water mark
module hqm_aqed_enq_ingress_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              hqm_gated_clk,
    input  logic              hqm_gated_rst_n,
    input  logic              in_v,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              in_ready,
    output logic              qed_aqed_enq_v,
    output logic [DATA_W-1:0] qed_aqed_enq_data,
    input  logic              qed_aqed_enq_rdy,
    output logic              err_par_v,
    output logic [7:0]        err_par_cnt,
    input  logic              cfg_hwm_clr,
    output logic [CNT_W-1:0]  status_depth,
    output logic [CNT_W-1:0]  status_hwm
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage and control state.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic [CNT_W-1:0]  hwm_q, hwm_d;
    logic              err_v_q, err_v_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    // Holds in_ready low through reset and releases it on the first clock after.
    logic              live_q, live_d;

    logic par_ok;
    logic push;
    logic good_push;
    logic bad_push;
    logic pull;

    // Handshake decode. Ready and valid come only from registered state, so
    // neither output combinationally depends on the opposite side's handshake.
    always_comb begin
        par_ok            = ^{in_data, in_par};
        in_ready          = live_q & (depth_q != FULL_CNT);
        qed_aqed_enq_v    = (depth_q != '0);
        // Gate with valid so never-written storage cannot leak X downstream.
        qed_aqed_enq_data = qed_aqed_enq_v ? mem_q[rd_ptr_q] : '0;
        push              = in_v & in_ready;
        good_push         = push & par_ok;
        bad_push          = push & ~par_ok;
        pull              = qed_aqed_enq_v & qed_aqed_enq_rdy;
    end

    // Next-state computation.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        depth_d   = depth_q;
        hwm_d     = hwm_q;
        err_v_d   = bad_push;
        err_cnt_d = err_cnt_q;
        live_d    = 1'b1;

        if (good_push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pull) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pull leaves the occupancy unchanged.
        case ({good_push, pull})
            2'b10:   depth_d = depth_q + CNT_W'(1);
            2'b01:   depth_d = depth_q - CNT_W'(1);
            default: depth_d = depth_q;
        endcase

        // Clear restarts tracking from the post-update occupancy, not from zero.
        if (cfg_hwm_clr) begin
            hwm_d = depth_d;
        end else if (depth_d > hwm_q) begin
            hwm_d = depth_d;
        end

        if (bad_push && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Payload storage carries no reset; the output gate above covers unwritten entries.
    always_ff @(posedge hqm_gated_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            depth_q   <= '0;
            hwm_q     <= '0;
            err_v_q   <= 1'b0;
            err_cnt_q <= 8'h00;
            live_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            depth_q   <= depth_d;
            hwm_q     <= hwm_d;
            err_v_q   <= err_v_d;
            err_cnt_q <= err_cnt_d;
            live_q    <= live_d;
        end
    end

    assign err_par_v    = err_v_q;
    assign err_par_cnt  = err_cnt_q;
    assign status_depth = depth_q;
    assign status_hwm   = hwm_q;

endmodule
